// File: rtl/bias_accum_relu.sv
// bias_accum_relu: per-lane bias + partial-sum accumulator feeding an arithmetic
// right shift, ReLU and unsigned saturation, emitted under a valid/ready handshake.
// Optional build macro BIAS_ROUND_EN: adds half an LSB before the shift (round-half-up).

module bias_accum_relu #(
    parameter int unsigned N_adder_tree = 16,
    parameter int unsigned IN_W         = 18,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned FRAC_SHIFT   = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_adder_tree*IN_W-1:0]    bias_q,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_adder_tree*IN_W-1:0]    in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_adder_tree*OUT_W-1:0]   out_data,
    output logic                            acc_sat
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] AccMax = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] AccMin = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] OutMax = SUM_W'({OUT_W{1'b1}});
`ifdef BIAS_ROUND_EN
    localparam logic signed [SUM_W-1:0] RndHalf = SUM_W'(1) << (FRAC_SHIFT - 1);
`endif

    typedef enum logic [1:0] {StIdle, StAccum, StFinal} state_e;

    state_e                         state_q, state_d;
    logic signed [ACC_W-1:0]        acc_q [N_adder_tree];
    logic signed [ACC_W-1:0]        acc_d [N_adder_tree];
    logic                           out_valid_q, out_valid_d;
    logic [N_adder_tree*OUT_W-1:0]  out_data_q, out_data_d;
    logic                           acc_sat_q, acc_sat_d;
    logic [N_adder_tree-1:0]        lane_clamp;
    logic [N_adder_tree*OUT_W-1:0]  lane_act;
    logic                           accept;

    assign in_ready  = (state_q != StFinal);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign acc_sat   = acc_sat_q;

    // Per-lane saturating add and the activation that the summed value would produce.
    always_comb begin : lane_math
        logic signed [IN_W-1:0]  bias_l;
        logic signed [IN_W-1:0]  in_l;
        logic signed [SUM_W-1:0] base;
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] clamped;
        logic signed [SUM_W-1:0] rnd;
        logic signed [SUM_W-1:0] shifted;
        lane_clamp = '0;
        lane_act   = '0;
        acc_d      = acc_q;
        bias_l     = '0;
        in_l       = '0;
        base       = '0;
        sum        = '0;
        clamped    = '0;
        rnd        = '0;
        shifted    = '0;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            bias_l = bias_q[i*IN_W +: IN_W];
            in_l   = in_data[i*IN_W +: IN_W];
            // First beat of a pixel starts from the bias, later beats from the accumulator.
            base   = (state_q == StIdle) ? SUM_W'(bias_l) : SUM_W'(acc_q[i]);
            sum    = base + SUM_W'(in_l);
            if (sum > AccMax) begin
                clamped       = AccMax;
                lane_clamp[i] = 1'b1;
            end else if (sum < AccMin) begin
                clamped       = AccMin;
                lane_clamp[i] = 1'b1;
            end else begin
                clamped = sum;
            end
            if (accept) begin
                acc_d[i] = clamped[ACC_W-1:0];
            end
`ifdef BIAS_ROUND_EN
            rnd = clamped + RndHalf;
`else
            rnd = clamped;
`endif
            shifted = rnd >>> FRAC_SHIFT;
            if (shifted[SUM_W-1]) begin
                lane_act[i*OUT_W +: OUT_W] = '0;
            end else if (shifted > OutMax) begin
                lane_act[i*OUT_W +: OUT_W] = '1;
            end else begin
                lane_act[i*OUT_W +: OUT_W] = shifted[OUT_W-1:0];
            end
        end
    end

    // Pixel sequencing, output capture on the last beat, sticky saturation flag.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_sat_d   = acc_sat_q;
        if (accept) begin
            // A new pixel clears the flag; later beats only add to it.
            acc_sat_d = (state_q == StIdle) ? (|lane_clamp) : (acc_sat_q | (|lane_clamp));
            if (in_last) begin
                state_d     = StFinal;
                out_valid_d = 1'b1;
                out_data_d  = lane_act;
            end else begin
                state_d = StAccum;
            end
        end else if (state_q == StFinal && out_ready) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset discarding any pending pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_sat_q   <= 1'b0;
            for (int unsigned i = 0; i < N_adder_tree; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_sat_q   <= acc_sat_d;
            for (int unsigned i = 0; i < N_adder_tree; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bias_accum_relu.sv
// Self-checking bench for bias_accum_relu: directed scenarios plus randomized pixels
// checked against an integer reference model of the accumulate/shift/ReLU/clip rules.

module tb_bias_accum_relu;

    localparam int N     = 16;
    localparam int IN_W  = 18;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;
    localparam int FS    = 6;
    localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (ACC_W - 1));
    localparam longint OMAX = (longint'(1) << OUT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N*IN_W-1:0]    bias_q = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*IN_W-1:0]    in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [N*OUT_W-1:0]   out_data;
    logic                 acc_sat;

    int n_checks = 0;
    int n_errors = 0;

    longint bias_l [N];
    longint beat_l [N];
    longint m_acc  [N];
    bit     m_idle = 1'b1;
    bit     m_sat  = 1'b0;
    logic [N*OUT_W-1:0] exp_word = '0;

    bias_accum_relu #(
        .N_adder_tree(N),
        .IN_W        (IN_W),
        .ACC_W       (ACC_W),
        .OUT_W       (OUT_W),
        .FRAC_SHIFT  (FS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bias_q   (bias_q),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .acc_sat  (acc_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N*OUT_W-1:0] got,
                         input logic [N*OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Reference activation: floor division by 2^FS, then ReLU and clip.
    function automatic logic [OUT_W-1:0] act(input longint sum);
        longint s;
        longint d;
        d = longint'(1) << FS;
        s = sum;
`ifdef BIAS_ROUND_EN
        s = s + d / 2;
`endif
        s = (s - (((s % d) + d) % d)) / d;
        if (s < 0) return '0;
        if (s > OMAX) return OUT_W'(OMAX);
        return OUT_W'(s);
    endfunction

    task automatic drive_bias();
        for (int i = 0; i < N; i++) bias_q[i*IN_W +: IN_W] = IN_W'(bias_l[i]);
    endtask

    task automatic set_bias_all(input longint v);
        for (int i = 0; i < N; i++) bias_l[i] = v;
        drive_bias();
    endtask

    task automatic set_beat_all(input longint v);
        for (int i = 0; i < N; i++) beat_l[i] = v;
    endtask

    task automatic send_beat(input bit last);
        int     n;
        longint v;
        bit     any;
        for (int i = 0; i < N; i++) in_data[i*IN_W +: IN_W] = IN_W'(beat_l[i]);
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_wait", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        if (last) check("pre_valid", out_valid, 0);
        @(posedge clk);
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            v = (m_idle ? bias_l[i] : m_acc[i]) + beat_l[i];
            if (v > AMAX) begin
                v = AMAX;
                any = 1'b1;
            end else if (v < AMIN) begin
                v = AMIN;
                any = 1'b1;
            end
            m_acc[i] = v;
        end
        m_sat = (m_idle ? 1'b0 : m_sat) | any;
        if (last) begin
            for (int i = 0; i < N; i++) exp_word[i*OUT_W +: OUT_W] = act(m_acc[i]);
            m_idle = 1'b1;
        end else begin
            m_idle = 1'b0;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("acc_sat", acc_sat, m_sat);
        if (last) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_word);
        end
    endtask

    task automatic finish_pixel(input int stall);
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp_word);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drop_valid", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, '0);
        check("rst_sat", acc_sat, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_idle = 1'b1;
        m_sat  = 1'b0;
    endtask

    initial begin
        logic [OUT_W-1:0] exp_r;
        int nb;
        bit big;
        longint mag;

        set_bias_all(0);
        set_beat_all(0);
        #12;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, '0);
        check("reset_sat", acc_sat, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // Basic accumulate: (64 + 3*128) >> 6 = 7 on every lane.
        set_bias_all(64);
        set_beat_all(128);
        send_beat(0);
        send_beat(0);
        send_beat(1);
        check("basic_lane0", out_data[OUT_W-1:0], 8'd7);
        finish_pixel(0);

        // ReLU clamp on lane 0.
        set_bias_all(0);
        bias_l[0] = -3012;
        drive_bias();
        set_beat_all(0);
        send_beat(1);
        check("relu_lane0", out_data[OUT_W-1:0], 8'd0);
        finish_pixel(0);

        // Output clip: 131071 >> 6 = 2047 -> 255.
        set_bias_all(0);
        set_beat_all(131071);
        send_beat(1);
        check("clip_all", out_data, {N{8'hff}});
        finish_pixel(0);

        // Backpressure with a held upstream beat.
        set_bias_all(100);
        set_beat_all(500);
        send_beat(1);
        set_beat_all(1000);
        for (int i = 0; i < N; i++) in_data[i*IN_W +: IN_W] = IN_W'(beat_l[i]);
        in_last  = 1'b1;
        in_valid = 1'b1;
        finish_pixel(5);
        send_beat(1);
        finish_pixel(0);

        // Accumulator saturation and its clearing on the next pixel.
        set_bias_all(0);
        set_beat_all(131071);
        for (int k = 0; k < 69; k++) send_beat(0);
        send_beat(1);
        check("sat_flag", acc_sat, 1);
        check("sat_out", out_data, {N{8'hff}});
        finish_pixel(2);
        set_beat_all(5);
        send_beat(0);
        check("sat_cleared", acc_sat, 0);
        send_beat(1);
        finish_pixel(0);

        // Reset mid-pixel, then a clean pixel: (64 + 64) >> 6 = 2.
        set_bias_all(7);
        set_beat_all(90000);
        send_beat(0);
        send_beat(0);
        do_reset();
        set_bias_all(64);
        set_beat_all(64);
        send_beat(1);
        check("post_reset_lane0", out_data[OUT_W-1:0], 8'd2);
        finish_pixel(0);

        // Reset while in FINAL discards the pending word.
        set_beat_all(3000);
        send_beat(1);
        do_reset();
        set_bias_all(-50);
        set_beat_all(1000);
        send_beat(1);
        finish_pixel(1);

        // Rounding: 480 >> 6 = 7 (floor), (480 + 32) >> 6 = 8 (rounded).
`ifdef BIAS_ROUND_EN
        exp_r = 8'd8;
`else
        exp_r = 8'd7;
`endif
        set_bias_all(480);
        set_beat_all(0);
        send_beat(1);
        check("round_lane0", out_data[OUT_W-1:0], exp_r);
        finish_pixel(0);

        // Randomized pixels, including mid-pixel bias changes and long saturating runs.
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < N; i++) bias_l[i] = longint'($urandom_range(262143)) - 131072;
            drive_bias();
            big = ($urandom_range(4) == 0);
            nb  = big ? int'($urandom_range(75, 68)) : int'($urandom_range(6, 1));
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < N; i++) begin
                    if (big) begin
                        mag = longint'($urandom_range(131071, 100000));
                        beat_l[i] = (i % 2 == 0) ? mag : -mag;
                    end else begin
                        beat_l[i] = longint'($urandom_range(262143)) - 131072;
                    end
                end
                send_beat(b == nb - 1);
                if (b == 0 && $urandom_range(3) == 0) begin
                    for (int i = 0; i < N; i++) begin
                        bias_l[i] = longint'($urandom_range(262143)) - 131072;
                    end
                    drive_bias();
                end
                if ($urandom_range(3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            finish_pixel(int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
